gx4000_asic_ram: RTL and testbench

Responder side of the GX4000 ASIC RAM fetch interface. Holds the 16 KB Plus ASIC page that Z80 writes reach at 0x4000–0x7FFF: sprite patterns, palette and sprite registers. Serves single-port, one-cycle-latency reads to the sprite/video renderer and arbitrates them against posted CPU writes and blocking CPU reads. Sits between the Z80 bus decoder and the sprite renderer, inside the GX4000 ASIC wrapper.

---
 rtl/gx4000_pkg.sv | 31 +++
 rtl/gx4000_asic_spram.sv | 25 ++
 rtl/gx4000_asic_ram.sv | 191 +++++++++++++++++++
 tb/tb_gx4000_asic_ram.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gx4000_pkg.sv
// Shared definitions for the GX4000 ASIC RAM page: address decode constants,
// the posted-write FIFO entry, the CPU read FSM encoding and the byte storage rule.
package gx4000_pkg;

  // Address bits 15:14 that select the ASIC page (0x4000-0x7FFF).
  localparam logic [1:0] ASIC_BASE      = 2'b01;
  // Index bits 13:12 of the sprite pattern region (0x4000-0x4FFF).
  localparam logic [1:0] PATTERN_REGION = 2'b00;

  // One posted CPU write waiting for a RAM slot.
  typedef struct packed {
    logic [13:0] idx;
    logic [7:0]  data;
  } asic_wr_t;

  // CPU read sequencer states.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  // Pattern pixels are 4-bit colour indices; the upper nibble is never stored.
  function automatic logic [7:0] store_byte(input logic [13:0] idx, input logic [7:0] din);
    if (idx[13:12] == PATTERN_REGION) begin
      return {4'h0, din[3:0]};
    end
    return din;
  endfunction

endpackage

// File: rtl/gx4000_asic_spram.sv
// 16384 x 8 single-port RAM with a registered read port. No reset so that
// it maps onto block RAM; the read register only updates on read cycles.
module gx4000_asic_spram (
  input  logic        clk_sys,
  input  logic        en,
  input  logic        we,
  input  logic [13:0] addr,
  input  logic [7:0]  d,
  output logic [7:0]  q
);

  logic [7:0] mem [0:16383];

  // One access per cycle: write, or read into the output register.
  always_ff @(posedge clk_sys) begin
    if (en) begin
      if (we) begin
        mem[addr] <= d;
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/gx4000_asic_ram.sv
// GX4000 ASIC RAM responder. Arbitrates one RAM port between renderer fetches,
// a 2-entry posted CPU write FIFO and blocking CPU reads, with a starvation
// counter that forces a CPU slot after STARVE_MAX consecutive video wins.
//
// Handshakes: vid_rd is a request, vid_gnt (combinational) says it is taken
// this cycle and vid_valid/vid_q follow one cycle later. cpu_wr is a one-cycle
// pulse acknowledged by cpu_ack the next cycle unless dropped; cpu_rd is held
// until the cycle cpu_ack is high, when cpu_dout carries the data.
module gx4000_asic_ram
  import gx4000_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        asic_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_busy,
  input  logic [13:0] vid_addr,
  input  logic        vid_rd,
  output logic        vid_gnt,
  output logic [7:0]  vid_q,
  output logic        vid_valid,
  output rd_state_t   dbg_rd_state
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  // Decode
  logic        cpu_hit;
  logic [13:0] cpu_idx;

  // Write FIFO
  asic_wr_t    fifo_mem [2];
  asic_wr_t    fifo_hd;
  asic_wr_t    push_entry;
  logic        fifo_head;
  logic [1:0]  fifo_cnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic        wr_slot;
  logic        push;
  logic        wr_ack_q;

  // Arbitration
  rd_state_t   rd_state;
  logic [CW-1:0] starve_cnt;
  logic        rd_pend;
  logic        cpu_pend;
  logic        force_slot;
  logic        cpu_slot_free;
  logic        drain;
  logic        rd_issue;

  // RAM port
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [7:0]  ram_q;

  logic [7:0]  dout_q;
  logic        vid_valid_q;

  assign cpu_hit = asic_en && (cpu_addr[15:14] == ASIC_BASE);
  assign cpu_idx = cpu_addr[13:0];

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_hd    = fifo_mem[fifo_head];
  // Tail slot is head + count (mod 2), taken from the pre-pop state so a
  // push into a full FIFO lands in the slot being popped this cycle.
  assign wr_slot    = fifo_head ^ fifo_cnt[0];

  // A read only counts as pending once the FSM is waiting for a slot.
  assign rd_pend       = (rd_state == RD_WAIT) && cpu_rd;
  assign cpu_pend      = !fifo_empty || rd_pend;
  assign force_slot    = cpu_pend && (starve_cnt == STARVE_LIM);
  assign vid_gnt       = vid_rd && !force_slot;
  assign cpu_slot_free = force_slot || !vid_rd;
  // The FIFO drains before any read, which keeps reads coherent with writes.
  assign drain         = !fifo_empty && cpu_slot_free;
  assign rd_issue      = rd_pend && fifo_empty && cpu_slot_free;
  // With the FIFO full, a write is still taken when the head pops this cycle.
  assign push          = cpu_wr && cpu_hit && (!fifo_full || drain);

  assign ram_en   = vid_gnt || drain || rd_issue;
  assign ram_we   = drain;
  assign ram_addr = drain ? fifo_hd.idx : (rd_issue ? cpu_idx : vid_addr);

  // Build the FIFO entry with the region storage rule already applied.
  always_comb begin
    push_entry      = '0;
    push_entry.idx  = cpu_idx;
    push_entry.data = store_byte(cpu_idx, cpu_din);
  end

  gx4000_asic_spram u_spram (
    .clk_sys (clk_sys),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .d       (fifo_hd.data),
    .q       (ram_q)
  );

  // FIFO payload storage; needs no reset because the count qualifies it.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_slot] <= push_entry;
    end
  end

  // FIFO pointers, occupancy and the write acknowledge pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fifo_head <= 1'b0;
      fifo_cnt  <= 2'd0;
      wr_ack_q  <= 1'b0;
    end else begin
      if (drain) begin
        fifo_head <= ~fifo_head;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, drain};
      wr_ack_q <= push;
    end
  end

  // Starvation counter: counts cycles a pending CPU op loses to video.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (drain || rd_issue || !cpu_pend) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // CPU read sequencer: wait for a slot, then present RAM data with the ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= RD_IDLE;
      dout_q   <= 8'h00;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (cpu_rd && cpu_hit) begin
            rd_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!cpu_rd) begin
            rd_state <= RD_IDLE;
          end else if (rd_issue) begin
            rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          dout_q   <= ram_q;
          rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Video data is valid the cycle after a granted fetch.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vid_valid_q <= 1'b0;
    end else begin
      vid_valid_q <= vid_gnt;
    end
  end

  // In RD_DATA the RAM register is passed straight through so data arrives
  // with the ack; afterwards the latched copy is held.
  assign cpu_dout     = (rd_state == RD_DATA) ? ram_q : dout_q;
  assign cpu_ack      = wr_ack_q || (rd_state == RD_DATA);
  assign cpu_busy     = fifo_full;
  assign vid_valid    = vid_valid_q;
  assign vid_q        = vid_valid_q ? ram_q : 8'h00;
  assign dbg_rd_state = rd_state;

endmodule

// File: tb/tb_gx4000_asic_ram.sv
// Bench for gx4000_asic_ram: directed scenarios followed by a randomized
// phase, all checked against a byte-array model of the ASIC page.
module tb_gx4000_asic_ram;
  import gx4000_pkg::*;

  localparam int STARVE = 8;

  // Clock / reset
  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        asic_en  = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_din  = 8'h00;
  logic        cpu_wr   = 1'b0;
  logic        cpu_rd   = 1'b0;
  logic [13:0] vid_addr = 14'h0000;
  logic        vid_rd   = 1'b0;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        cpu_busy;
  logic        vid_gnt;
  logic [7:0]  vid_q;
  logic        vid_valid;
  rd_state_t   dbg_rd_state;

  always #5 clk_sys = ~clk_sys;

  gx4000_asic_ram #(.STARVE_MAX(STARVE)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .asic_en      (asic_en),
    .cpu_addr     (cpu_addr),
    .cpu_din      (cpu_din),
    .cpu_wr       (cpu_wr),
    .cpu_rd       (cpu_rd),
    .cpu_dout     (cpu_dout),
    .cpu_ack      (cpu_ack),
    .cpu_busy     (cpu_busy),
    .vid_addr     (vid_addr),
    .vid_rd       (vid_rd),
    .vid_gnt      (vid_gnt),
    .vid_q        (vid_q),
    .vid_valid    (vid_valid),
    .dbg_rd_state (dbg_rd_state)
  );

  // Scoreboard and model
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  model [0:16383];
  logic [13:0] wr_list [$];
  logic [7:0]  exp_q [$];

  // Page contents as the CPU should see them: pattern pixels keep 4 bits.
  function automatic logic [7:0] stored(input logic [13:0] idx, input logic [7:0] d);
    if (idx < 14'h1000) return {4'h0, d[3:0]};
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Driver tasks: called and return at a falling edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic en, input string tag);
    int   waited = 0;
    logic hit;
    hit = en && (a >= 16'h4000) && (a < 16'h8000);
    while (cpu_busy && waited < 40) begin
      @(negedge clk_sys);
      waited++;
    end
    asic_en  = en;
    cpu_addr = a;
    cpu_din  = d;
    cpu_wr   = 1'b1;
    @(negedge clk_sys);
    cpu_wr  = 1'b0;
    asic_en = 1'b1;
    chk({tag, "_wr_ack"}, cpu_ack, hit);
    if (hit) model[a[13:0]] = stored(a[13:0], d);
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input int exp_lat, input string tag);
    int   lat = 0;
    logic got = 1'b0;
    cpu_addr = a;
    cpu_rd   = 1'b1;
    while (!got && lat < 40) begin
      @(negedge clk_sys);
      lat++;
      if (cpu_ack) got = 1'b1;
    end
    chk({tag, "_rd_ack"}, got, 1);
    if (exp_lat > 0) chk({tag, "_rd_lat"}, lat, exp_lat);
    chk({tag, "_rd_data"}, cpu_dout, exp);
    cpu_rd = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic cpu_read_miss(input logic [15:0] a, input logic en);
    int acks = 0;
    asic_en  = en;
    cpu_addr = a;
    cpu_rd   = 1'b1;
    repeat (4) begin
      @(negedge clk_sys);
      if (cpu_ack) acks++;
    end
    cpu_rd  = 1'b0;
    asic_en = 1'b1;
    chk("rdmiss_ack", acks, 0);
    chk("rdmiss_state", dbg_rd_state, RD_IDLE);
    @(negedge clk_sys);
  endtask

  task automatic vid_fetch(input logic [13:0] idx, input string tag);
    vid_addr = idx;
    vid_rd   = 1'b1;
    #1;
    chk({tag, "_gnt"}, vid_gnt, 1);
    exp_q.push_back(model[idx]);
    @(negedge clk_sys);
    vid_rd = 1'b0;
    chk({tag, "_valid"}, vid_valid, 1);
    chk({tag, "_q"}, vid_q, exp_q.pop_front());
  endtask

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        en;
    logic [13:0] idx;
    int          op;
    int          pre;
    int          lows;
    int          acks;
    logic        g;
    logic        prev_g;
    logic        found;

    // Reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_cpu_dout", cpu_dout, 8'h00);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_busy", cpu_busy, 0);
    chk("rst_vid_q", vid_q, 8'h00);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_state", dbg_rd_state, RD_IDLE);
    reset_n = 1'b1;
    idle(2);

    // Pattern write keeps only the low nibble; uncontended read latency 2
    cpu_write(16'h4105, 8'hA7, 1'b1, "t1");
    idle(1);
    cpu_read(16'h4105, 8'h07, 2, "t1");

    // Palette region stores the full byte
    cpu_write(16'h6400, 8'hA7, 1'b1, "t2");
    idle(1);
    cpu_read(16'h6400, 8'hA7, 2, "t2");

    // Page not mapped / address outside the page: ignored
    cpu_write(16'h4000, 8'h3C, 1'b1, "t3a");
    idle(1);
    cpu_write(16'h4000, 8'h05, 1'b0, "t3b");
    cpu_write(16'hC000, 8'h99, 1'b1, "t3c");
    idle(2);
    cpu_read(16'h4000, 8'h0C, 2, "t3");
    cpu_read_miss(16'h4000, 1'b0);

    // Continuous video: one forced CPU slot after STARVE blocked cycles
    vid_addr = 14'h0105;
    vid_rd   = 1'b1;
    idle(2);
    cpu_write(16'h6000, 8'h55, 1'b1, "t4");
    pre    = 0;
    lows   = 0;
    prev_g = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      g = vid_gnt;
      chk("t4_vid_valid", vid_valid, prev_g);
      if (prev_g) chk("t4_vid_q", vid_q, model[14'h0105]);
      if (!g) lows++;
      else if (lows == 0) pre++;
      prev_g = g;
      @(negedge clk_sys);
    end
    chk("t4_blocked_cycles", pre, STARVE);
    chk("t4_gnt_drops", lows, 1);
    vid_rd = 1'b0;
    idle(2);
    vid_fetch(14'h2000, "t4_fetch");

    // Back-to-back writes under video fill the FIFO
    vid_addr = 14'h0105;
    vid_rd   = 1'b1;
    idle(2);
    cpu_write(16'h5010, 8'h11, 1'b1, "t5a");
    cpu_write(16'h6011, 8'h22, 1'b1, "t5b");
    chk("t5_busy_after_2nd", cpu_busy, 1);
    cpu_write(16'h7012, 8'h33, 1'b1, "t5c");
    vid_rd = 1'b0;
    idle(4);
    cpu_read(16'h5010, 8'h11, 2, "t5a");
    cpu_read(16'h6011, 8'h22, 2, "t5b");
    cpu_read(16'h7012, 8'h33, 2, "t5c");

    // Write on the forced drain cycle with a full FIFO is accepted
    vid_rd = 1'b1;
    idle(2);
    cpu_write(16'h5020, 8'h44, 1'b1, "t5d");
    cpu_write(16'h5021, 8'h66, 1'b1, "t5e");
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (!vid_gnt) found = 1'b1;
      else @(negedge clk_sys);
    end
    chk("t5f_force_seen", found, 1);
    chk("t5f_busy_at_force", cpu_busy, 1);
    cpu_addr = 16'h5022;
    cpu_din  = 8'h77;
    cpu_wr   = 1'b1;
    @(negedge clk_sys);
    cpu_wr = 1'b0;
    chk("t5f_wr_ack", cpu_ack, 1);
    model[14'h1022] = stored(14'h1022, 8'h77);
    vid_rd = 1'b0;
    idle(5);
    cpu_read(16'h5020, 8'h44, 2, "t5d");
    cpu_read(16'h5021, 8'h66, 2, "t5e");
    cpu_read(16'h5022, 8'h77, 2, "t5f");

    // Reset while the read waits behind video
    vid_addr = 14'h0105;
    vid_rd   = 1'b1;
    cpu_addr = 16'h6400;
    cpu_rd   = 1'b1;
    @(negedge clk_sys);
    chk("t6_state_wait", dbg_rd_state, RD_WAIT);
    chk("t6_vid_valid_pre", vid_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_cpu_dout", cpu_dout, 8'h00);
    chk("t6_cpu_ack", cpu_ack, 0);
    chk("t6_cpu_busy", cpu_busy, 0);
    chk("t6_vid_q", vid_q, 8'h00);
    chk("t6_vid_valid", vid_valid, 0);
    chk("t6_state_idle", dbg_rd_state, RD_IDLE);
    cpu_rd = 1'b0;
    vid_rd = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (cpu_ack) acks++;
    end
    chk("t6_no_ack_after", acks, 0);
    cpu_read(16'h6400, model[14'h2400], 2, "t6_ram_kept");

    // Randomized phase
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op < 4 || wr_list.size() == 0) begin
        a  = {2'b01, 14'($urandom_range(0, 16383))};
        d  = 8'($urandom_range(0, 255));
        en = ($urandom_range(0, 5) != 0);
        if ($urandom_range(0, 7) == 0) a[15:14] = 2'($urandom_range(0, 3));
        cpu_write(a, d, en, "rnd");
        if (en && a[15:14] == 2'b01) wr_list.push_back(a[13:0]);
        idle(1);
      end else if (op < 7) begin
        idx = wr_list[$urandom_range(0, wr_list.size() - 1)];
        cpu_read({2'b01, idx}, model[idx], 2, "rnd");
      end else if (op < 9) begin
        idx = wr_list[$urandom_range(0, wr_list.size() - 1)];
        vid_fetch(idx, "rnd_vid");
      end else begin
        a = {2'b01, 14'($urandom_range(0, 16383))};
        if ($urandom_range(0, 1) == 1) begin
          cpu_read_miss(a, 1'b0);
        end else begin
          a[15:14] = 2'b01 ^ 2'($urandom_range(1, 3));
          cpu_read_miss(a, 1'b1);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
